// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES_top core between two job requesters (ch0, ch1).
// Optional watchdog abort of a stalled core: define AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         busy,
  output logic         core_en,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_valid
);

`ifdef AES_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_e;

  state_e       state_q, state_d;
  logic         rr_q, rr_d, gid_q, gid_d, rerr_q, rerr_d;
  logic [127:0] din_q, din_d, key_q, key_d, rdat_q, rdat_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic         grant_vld, grant_id, timeout;

  // rr_q names the preferred channel; fall back to the other one.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr_q;
    if (rr_q ? req1_valid : req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = rr_q;
    end else if (rr_q ? req0_valid : req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~rr_q;
    end
  end

  assign timeout = TO_ON && (cnt_q >= TO_LIM);

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gid_q   <= 1'b0;
      rerr_q  <= 1'b0;
      din_q   <= '0;
      key_q   <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      rerr_q  <= rerr_d;
      din_q   <= din_d;
      key_q   <= key_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    rerr_d  = rerr_q;
    din_d   = din_q;
    key_d   = key_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (grant_vld) begin
        state_d = RUN;
        gid_d   = grant_id;
        rr_d    = ~grant_id;
        din_d   = grant_id ? req1_data : req0_data;
        key_d   = grant_id ? req1_key  : req0_key;
        cnt_d   = '0;
      end
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // A real result beats a watchdog expiry in the same cycle.
        if (core_data_out_valid) begin
          state_d = RESP;
          rdat_d  = core_data_out;
          rerr_d  = 1'b0;
        end else if (timeout) begin
          state_d = RESP;
          rdat_d  = '0;
          rerr_d  = 1'b1;
        end
      end
      RESP: if (rsp_ready) state_d = GAP;
      GAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_en    = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant_vld & ~grant_id;
        req1_ready = grant_vld &  grant_id;
      end
      RUN:  core_en   = 1'b1;
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign core_data_in = din_q;
  assign core_key_in  = key_q;
  assign rsp_data     = rdat_q;
  assign rsp_id       = gid_q;
  assign rsp_err      = rerr_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: transaction-level model plus a latency-L core model.
`timescale 1ns/1ps
module tb_aes_core_arbiter;
  localparam int L   = 11;
  localparam int TOC = 64;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic         rsp_valid, rsp_ready = 1, rsp_id, rsp_err, busy, core_en;
  logic [127:0] rsp_data, core_data_in, core_key_in, core_data_out;
  logic         core_data_out_valid;

  aes_core_arbiter #(.TIMEOUT_CYC(TOC), .TO_W(7)) dut (
    .AES_clk(clk), .AES_rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy), .core_en(core_en), .core_data_in(core_data_in),
    .core_key_in(core_key_in), .core_data_out(core_data_out),
    .core_data_out_valid(core_data_out_valid));

  // Stand-in cipher: the known AES vector, otherwise an arbitrary mix.
  function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
    if (d == PT && k == KEY) return CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0;
  endfunction

  // Core model: valid pulses once after L enabled edges; hang suppresses it.
  int   core_cnt = 0;
  logic core_v = 0, hang = 0, spur = 0;
  always @(posedge clk) begin
    if (!core_en) begin core_cnt <= 0; core_v <= 0; end
    else begin core_cnt <= core_cnt + 1; core_v <= !hang && (core_cnt + 1 == L); end
  end
  assign core_data_out_valid = core_v | spur;
  assign core_data_out       = cipher(core_data_in, core_key_in);

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Transaction model: one job in flight, fixed latency, one idle GAP after each response.
  typedef struct packed { logic id; logic err; logic [127:0] data; } rsp_t;
  rsp_t m_q[$];
  logic ids_seen[$];
  bit   chk_on = 0, m_inflight = 0, m_gap = 0, m_rr = 0, gv, gi, exp_en, exp_rv, was_gap, hs;
  logic [1:0]   vv;
  logic [127:0] m_data, m_key, seen_data;
  logic         seen_id, seen_err;
  int cyc = 0, m_gcyc = 0, m_due = 0, n_rsp = 0, en_cnt = 0, rsp_first = -1;
  int low_run = 0, min_gap = 1000;
  bit seen_run = 0;

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      vv = {req1_valid, req0_valid};
      gv = 0; gi = m_rr;
      if (!m_inflight && !m_gap) begin
        if (vv[m_rr]) begin gv = 1; gi = m_rr; end
        else if (vv[!m_rr]) begin gv = 1; gi = !m_rr; end
      end
      exp_en = m_inflight && cyc > m_gcyc && cyc < m_due;
      exp_rv = m_inflight && cyc >= m_due;
      chk("req0_ready", req0_ready, gv && !gi);
      chk("req1_ready", req1_ready, gv && gi);
      chk("busy", busy, m_inflight || m_gap);
      chk("core_en", core_en, exp_en);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_en) begin
        chk("core_data_in", core_data_in, m_data);
        chk("core_key_in", core_key_in, m_key);
      end
      if (exp_rv && m_q.size() > 0) begin
        chk("rsp_data", rsp_data, m_q[0].data);
        chk("rsp_id", rsp_id, m_q[0].id);
        chk("rsp_err", rsp_err, m_q[0].err);
      end
      if (core_en) begin
        en_cnt++;
        if (seen_run && low_run > 0 && low_run < min_gap) min_gap = low_run;
        seen_run = 1; low_run = 0;
      end else low_run++;
      if (rsp_valid && rsp_first < 0) begin
        rsp_first = cyc; seen_data = rsp_data; seen_id = rsp_id; seen_err = rsp_err;
      end
      was_gap = m_gap;
      hs = exp_rv && rsp_ready;
      if (was_gap) m_gap = 0;
      if (hs) begin
        ids_seen.push_back(rsp_id);
        if (m_q.size() > 0) void'(m_q.pop_front());
        n_rsp++; m_inflight = 0; m_gap = 1;
      end
      if (gv) begin
        m_data = gi ? req1_data : req0_data;
        m_key  = gi ? req1_key  : req0_key;
        m_q.push_back(hang ? rsp_t'{gi, 1'b1, 128'h0} : rsp_t'{gi, 1'b0, cipher(m_data, m_key)});
        m_inflight = 1; m_gcyc = cyc; m_due = cyc + (hang ? TOC + 2 : L + 2);
        m_rr = !gi; en_cnt = 0; rsp_first = -1;
      end
      if (!rst_n) begin m_q.delete(); m_inflight = 0; m_gap = 0; m_rr = 0; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string nm);
    int t = 0;
    while (n_rsp < n && t < budget) begin tick(1); t++; end
    n_cmp++;
    if (n_rsp < n) begin
      n_err++;
      $display("FAIL %s: timed out with %0d responses, required %0d", nm, n_rsp, n);
    end
  endtask

  task automatic offer(input bit ch, input logic [127:0] d, input logic [127:0] k, input string nm);
    int t = 0; bit got = 0;
    if (ch) begin req1_valid = 1; req1_data = d; req1_key = k; end
    else    begin req0_valid = 1; req0_data = d; req0_key = k; end
    while (!got && t < 200) begin @(negedge clk); got = ch ? req1_ready : req0_ready; t++; end
    tick(1);
    if (ch) req1_valid = 0; else req0_valid = 0;
    chk({nm, "_granted"}, got, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    bit got;
    tick(2);
    // Reset state
    chk("rst_core_en", core_en, 0);      chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);  chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);        chk("rst_rsp_err", rsp_err, 0);
    chk("rst_core_data_in", core_data_in, 0); chk("rst_core_key_in", core_key_in, 0);
    chk("rst_req0_ready", req0_ready, 0);     chk("rst_req1_ready", req1_ready, 0);
    rst_n = 1; chk_on = 1;

    // Spurious core valid while idle
    spur = 1; tick(1); spur = 0; tick(3);
    chk("spur_rsp_valid", rsp_valid, 0); chk("spur_busy", busy, 0);

    // Both channels continuously valid: strict alternation starting at ch0
    min_gap = 1000; seen_run = 0; ids_seen.delete();
    req0_valid = 1; req0_data = 128'h1111; req0_key = 128'haaaa;
    req1_valid = 1; req1_data = 128'h2222; req1_key = 128'hbbbb;
    wait_rsp(n_rsp + 8, 8 * (L + 4) + 40, "alt_jobs");
    req0_valid = 0; req1_valid = 0;
    chk("alt_count", ids_seen.size(), 8);
    for (int i = 0; i < 8 && i < ids_seen.size(); i++) chk($sformatf("alt_id%0d", i), ids_seen[i], i % 2);
    chk("alt_en_gap_ge2", min_gap >= 2, 1);
    tick(4);

    // Single ch0 job with the reference vector
    base = n_rsp;
    offer(0, PT, KEY, "single");
    wait_rsp(base + 1, 60, "single_rsp");
    chk("single_latency", rsp_first - m_gcyc, 13);
    chk("single_data", seen_data, CT);
    chk("single_id", seen_id, 0);
    chk("single_err", seen_err, 0);
    chk("single_en_cycles", en_cnt, L + 1);
    tick(3);

    // Backpressure: response held, ch1 kept waiting
    base = n_rsp; rsp_ready = 0;
    offer(0, 128'h3333, 128'hcccc, "bp_job0");
    req1_valid = 1; req1_data = 128'h4444; req1_key = 128'hdddd;
    t = 0;
    while (!rsp_valid && t < 60) begin tick(1); t++; end
    chk("bp_rsp_arrived", rsp_valid, 1);
    tick(20);
    chk("bp_still_valid", rsp_valid, 1);
    chk("bp_data_held", rsp_data, cipher(128'h3333, 128'hcccc));
    chk("bp_id_held", rsp_id, 0);
    chk("bp_req1_blocked", req1_ready, 0);
    chk("bp_no_rsp_yet", n_rsp, base);
    rsp_ready = 1;
    offer(1, 128'h4444, 128'hdddd, "bp_job1");
    wait_rsp(base + 2, 60, "bp_rsp");
    tick(10);
    chk("bp_one_rsp_per_job", n_rsp, base + 2);

    // Reset in RUN cycle 5 drops the job and restores ch0 preference
    offer(0, 128'h5555, 128'heeee, "rst_job");
    tick(5);
    rst_n = 0; tick(1);
    chk("midrst_core_en", core_en, 0); chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    rst_n = 1; base = n_rsp;
    req0_valid = 1; req0_data = 128'h6666; req0_key = 128'h7777;
    req1_valid = 1; req1_data = 128'h8888; req1_key = 128'h9999;
    got = 0; t = 0;
    while (!got && t < 20) begin @(negedge clk); got = req0_ready | req1_ready; t++; end
    chk("midrst_ch0_first", req0_ready, 1);
    chk("midrst_ch1_waits", req1_ready, 0);
    tick(1); req0_valid = 0; req1_valid = 0;
    wait_rsp(base + 1, 60, "midrst_rsp");
    chk("midrst_rsp_id", seen_id, 0);
    tick(20);
    chk("midrst_no_dropped_rsp", n_rsp, base + 1);

`ifdef AES_ARB_TIMEOUT_EN
    // Watchdog abort, then a normal job
    base = n_rsp; hang = 1;
    offer(1, 128'habcd, 128'h1234, "to_job");
    wait_rsp(base + 1, TOC + 40, "to_rsp");
    hang = 0;
    chk("to_latency", rsp_first - m_gcyc, TOC + 2);
    chk("to_err", seen_err, 1);
    chk("to_data", seen_data, 0);
    chk("to_id", seen_id, 1);
    tick(3);
    offer(0, PT, KEY, "to_next");
    wait_rsp(base + 2, 60, "to_next_rsp");
    chk("to_next_err", seen_err, 0);
    chk("to_next_data", seen_data, CT);
`endif

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
